// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter feeding one serializer parallel port from several byte buffers.
// Optional TX_ARB_HEADER_EN prefixes every grant with a header byte 8'hF0 | grant.
module serial_tx_arbiter #(
   parameter int CHANNELS   = 4,
   parameter int CHAN_BITS  = 2,
   parameter int MAX_BURST  = 8,
   parameter int BURST_BITS = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [CHANNELS-1:0]     req_full,
   input  logic [8*CHANNELS-1:0]   req_data,
   output logic [CHANNELS-1:0]     req_strobe,
   output logic [7:0]              par_data,
   output logic                    par_ready,
   input  logic                    par_strobe,
   output logic [CHAN_BITS-1:0]    grant,
   output logic                    busy
);

`ifdef TX_ARB_HEADER_EN
   typedef enum logic [2:0] {S_IDLE, S_HEADER, S_FETCH, S_OFFER, S_NEXT} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_OFFER, S_NEXT} state_t;
`endif

   state_t                  state, state_d;
   logic [CHAN_BITS-1:0]    last_grant, last_grant_d;
   logic [CHAN_BITS-1:0]    grant_d;
   logic [BURST_BITS-1:0]   burst_count, burst_d;
   logic [7:0]              par_data_d;
   logic                    par_ready_d;
   logic [CHANNELS-1:0]     strobe_d;

   logic                    hit;
   logic [CHAN_BITS-1:0]    hit_idx;
   logic [CHAN_BITS-1:0]    cand;
   logic                    gsel_full;
   logic [7:0]              gsel_data;

   function automatic logic [CHAN_BITS-1:0] wrap_inc(input logic [CHAN_BITS-1:0] base,
                                                     input int k);
      int sum;
      sum = int'(base) + k;
      if (sum >= CHANNELS) sum = sum - CHANNELS;
      return CHAN_BITS'(sum);
   endfunction

   // Priority starts one past the previous winner so every requester gets a turn.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      cand    = '0;
      for (int k = 1; k <= CHANNELS; k++) begin
         cand = wrap_inc(last_grant, k);
         if (!hit && req_full[cand]) begin
            hit     = 1'b1;
            hit_idx = cand;
         end
      end
   end

   assign gsel_full = req_full[grant];
   assign gsel_data = req_data[8*grant +: 8];
   assign busy      = (state != S_IDLE);

   always_comb begin
      state_d      = state;
      last_grant_d = last_grant;
      grant_d      = grant;
      burst_d      = burst_count;
      par_data_d   = par_data;
      par_ready_d  = par_ready;
      strobe_d     = '0;
      case (state)
         S_IDLE: begin
            if (hit) begin
               grant_d = hit_idx;
               burst_d = '0;
`ifdef TX_ARB_HEADER_EN
               par_data_d  = 8'hF0 | 8'(hit_idx);
               par_ready_d = 1'b1;
               state_d     = S_HEADER;
`else
               state_d     = S_FETCH;
`endif
            end
         end
`ifdef TX_ARB_HEADER_EN
         S_HEADER: begin
            if (par_strobe) begin
               par_ready_d = 1'b0;
               state_d     = S_FETCH;
            end
         end
`endif
         S_FETCH: begin
            if (gsel_full) begin
               par_data_d      = gsel_data;
               strobe_d[grant] = 1'b1;
               par_ready_d     = 1'b1;
               state_d         = S_OFFER;
            end else begin
               last_grant_d = grant;
               state_d      = S_IDLE;
            end
         end
         S_OFFER: begin
            if (par_strobe) begin
               par_ready_d = 1'b0;
               burst_d     = burst_count + 1'b1;
               state_d     = S_NEXT;
            end
         end
         // One-cycle holdoff so the pop has reached req_full before it is judged.
         S_NEXT: begin
            if (burst_count == BURST_BITS'(MAX_BURST) || !gsel_full) begin
               last_grant_d = grant;
               state_d      = S_IDLE;
            end else begin
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         last_grant  <= CHAN_BITS'(CHANNELS - 1);
         grant       <= '0;
         burst_count <= '0;
         par_data    <= 8'h00;
         par_ready   <= 1'b0;
         req_strobe  <= '0;
      end else begin
         state       <= state_d;
         last_grant  <= last_grant_d;
         grant       <= grant_d;
         burst_count <= burst_d;
         par_data    <= par_data_d;
         par_ready   <= par_ready_d;
         req_strobe  <= strobe_d;
      end
   end

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Round-robin arbiter that shares one `serializer` parallel port among several byte producers, each presenting a `shallow_buffer`-style output (full flag, data, rising-edge pop strobe). The arbiter grants one channel at a time for a burst of up to MAX_BURST bytes, then rotates. It pops each byte from the granted buffer and offers it to the serializer with a level `par_ready` handshake. It sits between the per-endpoint transmit buffers and the single shared serial output path.

## Interface
- CHANNELS, 4: number of requesters; 2..16.
- CHAN_BITS, 2: width of `grant`; 2^CHAN_BITS ≥ CHANNELS.
- MAX_BURST, 8: bytes per grant before forced rotation; 1..2^BURST_BITS−1.
- BURST_BITS, 4: width of the burst counter.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (low = reset).
- req_full  in  CHANNELS  bit i high: channel i holds a byte.
- req_data  in  8*CHANNELS  channel i byte at bits [8i+7:8i].
- req_strobe  out  CHANNELS  one-cycle pop pulse to channel i; low between pulses.
- par_data  out  8  byte offered to the serializer.
- par_ready  out  1  par_data valid; held until par_strobe.
- par_strobe  in  1  serializer has taken par_data.
- grant  out  CHAN_BITS  currently or last granted channel.
- busy  out  1  high in every state except S_IDLE.

## Operation
- States: S_IDLE, S_HEADER (macro only), S_FETCH, S_OFFER, S_NEXT.
- S_IDLE: search from last_grant+1 upward, mod CHANNELS, for the first set req_full bit. On a hit: grant<=i, burst_count<=0, busy<=1, go to S_HEADER or S_FETCH. On no hit, stay.
- S_FETCH: if req_full[grant] is high: par_data<=req_data[grant], req_strobe[grant]<=1, par_ready<=1, go to S_OFFER. If it is low: last_grant<=grant, go to S_IDLE with no pop.
- S_OFFER: req_strobe<=0. When par_strobe is high: par_ready<=0, burst_count<=burst_count+1, go to S_NEXT.
- S_NEXT: this cycle is a holdoff that lets the pop reach req_full.
  - If burst_count==MAX_BURST or req_full[grant] is low: last_grant<=grant, go to S_IDLE.
  - Otherwise go to S_FETCH.
- par_strobe is ignored outside S_OFFER/S_HEADER.
- Bytes are never reordered, duplicated or dropped once popped.
- req_full bits of non-granted channels are ignored until the next S_IDLE.

## Timing
- Reset values: req_strobe 0, par_ready 0, par_data 0x00, grant 0, busy 0, last_grant CHANNELS−1 (channel 0 has first priority), state S_IDLE.
- Reset is asynchronous. Asserting it mid-burst returns to S_IDLE immediately, and an offered byte is lost. The serializer and buffers are reset by the same signal.
- Latency: req_full rises in cycle 0 while idle → S_FETCH in cycle 1 → req_strobe and par_ready high in cycle 2 (no header).
- req_strobe is high for exactly one cycle per byte, with at least 2 low cycles between pulses to the same channel.
- par_ready drops in the cycle after par_strobe is sampled high. The serializer recaptures no earlier than 7 cycles later, so no duplicate capture occurs.
- Minimum per-byte period within a burst is 4 cycles (FETCH, OFFER ×2, NEXT). The serializer needs 8, so the arbiter is never the bottleneck.
- If every channel is full, grants rotate 0→1→2→3→0, each for MAX_BURST bytes.
- A channel that empties mid-burst ends its grant at S_NEXT. A refill during S_NEXT continues the burst.

## Configuration
- Macro TX_ARB_HEADER_EN.
- Defined: after each grant the FSM enters S_HEADER.
  - par_data<=8'hF0|grant, par_ready<=1.
  - On par_strobe: par_ready<=0, go to S_FETCH.
  - The header does not count toward burst_count.
- Undefined: S_HEADER and its logic are absent; S_IDLE goes directly to S_FETCH. The serial stream carries payload bytes only.

## Test plan
- Reset held low with req_full=4'hF → all outputs at reset values. Release → first req_strobe on channel 0, with par_ready high 2 cycles after release.
- Channel 2 alone holds 3 bytes 0x11, 0x22, 0x33 behind a real serializer → serial stream is 0x11 0x22 0x33 MSB-first with no gaps. Exactly 3 req_strobe[2] pulses, then busy falls.
- All four channels continuously full, MAX_BURST=2 → par_data channel order 0,0,1,1,2,2,3,3,0,0.
- par_strobe held off for 20 cycles in S_OFFER → par_ready and par_data stable for all 20 cycles, no extra req_strobe. par_strobe pulse → par_ready low the next cycle.
- req_full[1] drops between grant and S_FETCH → no req_strobe[1], return to S_IDLE, next grant goes to channel 2 if it is full.
- TX_ARB_HEADER_EN with channel 3 byte 0xA5 → serializer receives 0xF3 then 0xA5. Without the macro → 0xA5 only.
